// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   state_e   : arbiter FSM states
//   idx_width : width of a requester index for n requesters (never below 1)
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin picker: returns the first set bit of req_i searching upward
// from last_i+1 and wrapping around.
//   req_i   [NREQ] request mask
//   last_i  [IW]   index granted most recently
//   found_o        any request present
//   idx_o   [IW]   chosen index (0 when nothing is found)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic            found_o,
  output logic [IW-1:0]   idx_o
);

  logic [2*NREQ-1:0] dbl;
  logic [IW-1:0]     start;
  logic [IW:0]       pos;

  // The mask is laid out twice so the wrap-around search becomes a plain
  // upward scan from start; iterating downward lets the nearest hit win.
  // An out-of-range last index restarts the search at 0.
  always_comb begin
    dbl     = {req_i, req_i};
    start   = (last_i >= IW'(NREQ - 1)) ? '0 : last_i + 1'b1;
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      pos = {1'b0, start} + (IW + 1)'(j);
      if (dbl[pos]) begin
        found_o = 1'b1;
        idx_o   = (pos >= (IW + 1)'(NREQ)) ? IW'(pos - (IW + 1)'(NREQ)) : IW'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares the async_fifo write port among NREQ requesters with round-robin
// grants, bounded bursts and optional early release on almost-full.
//   wclk, wrst          write clock, synchronous active-high reset
//   req_valid/req_data  per-requester valid and data (slot i at [i*DSIZE +: DSIZE])
//   req_ready           per-requester accept
//   winc/wdata          FIFO write enable and data
//   wfull/awfull        FIFO full / almost full
//   grant, busy         one-hot current owner, high while granted
//   beat_count          beats written since reset (wraps)
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin
// GRANT | grant_idx owns the write port until burst end or release
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE           = 8,
  parameter int NREQ            = 4,
  parameter int BURST_MAX       = 4,
  parameter int THROTTLE_AWFULL = 1,
  parameter int CNTW            = 16
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  input  logic                  wfull,
  input  logic                  awfull,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [CNTW-1:0]       beat_count
);

  localparam int       IW         = idx_width(NREQ);
  localparam logic     THR        = (THROTTLE_AWFULL != 0);
  localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_idx_q, grant_idx_d;
  logic [IW-1:0]   rr_last_q, rr_last_d;
  logic [7:0]      burst_cnt_q, burst_cnt_d;
  logic [CNTW-1:0] beat_count_q, beat_count_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            g_valid;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i   (req_valid),
    .last_i  (rr_last_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Owner's valid and data; wdata follows the owner even when no beat.
  always_comb begin
    g_valid = 1'b0;
    wdata   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx_q == IW'(i)) begin
        g_valid = req_valid[i];
        wdata   = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    rr_last_d    = rr_last_q;
    burst_cnt_d  = burst_cnt_q;
    beat_count_d = beat_count_q;
    grant        = '0;
    req_ready    = '0;
    winc         = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          grant_idx_d = pick_idx;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        busy                   = 1'b1;
        grant[grant_idx_q]     = 1'b1;
        req_ready[grant_idx_q] = ~wfull;
        winc                   = g_valid & ~wfull;
        if (winc) begin
          burst_cnt_d  = burst_cnt_q + 8'd1;
          beat_count_d = beat_count_q + 1'b1;
        end
        // Release on last beat, owner going quiet, or almost-full throttling
        // (after a beat, or immediately if the FIFO is stalled full).
        if ((winc && burst_cnt_q == BURST_LAST) || !g_valid ||
            (THR && awfull && (winc || wfull))) begin
          state_d   = IDLE;
          rr_last_d = grant_idx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      rr_last_q    <= IW'(NREQ - 1);
      burst_cnt_q  <= '0;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      rr_last_q    <= rr_last_d;
      burst_cnt_q  <= burst_cnt_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: two instances (almost-full throttling on and
// off) share stimulus; a queue-level owner/burst model is checked every cycle.
module tb_fifo_write_arbiter;

  localparam int DSIZE     = 8;
  localparam int NREQ      = 4;
  localparam int BURST_MAX = 4;
  localparam int CNTW      = 16;

  logic wclk = 1'b0;
  always #5 wclk = ~wclk;

  logic                  wrst;
  logic [NREQ-1:0]       req_valid;
  logic                  wfull, awfull;
  logic [NREQ*DSIZE-1:0] req_data   [2];
  logic [NREQ-1:0]       req_ready  [2];
  logic [NREQ-1:0]       grant      [2];
  logic                  winc       [2];
  logic                  busy       [2];
  logic [DSIZE-1:0]      wdata      [2];
  logic [CNTW-1:0]       beat_count [2];

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Requester streams: requester i sends i*64 + (seq mod 64), seq advancing
  // on every accepted beat, separately for each instance.
  int seq [2][NREQ];
  logic [NREQ-1:0] hs [2];

  for (genvar k = 0; k < 2; k++) begin : g_data
    for (genvar i = 0; i < NREQ; i++) begin : g_req
      assign req_data[k][i*DSIZE +: DSIZE] = DSIZE'(i * 64 + (seq[k][i] % 64));
    end
  end

  fifo_write_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST_MAX(BURST_MAX),
                       .THROTTLE_AWFULL(1), .CNTW(CNTW)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data[0]),
    .req_ready(req_ready[0]), .winc(winc[0]), .wdata(wdata[0]), .wfull(wfull),
    .awfull(awfull), .grant(grant[0]), .busy(busy[0]), .beat_count(beat_count[0])
  );

  fifo_write_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST_MAX(BURST_MAX),
                       .THROTTLE_AWFULL(0), .CNTW(CNTW)) dut_nothr (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data[1]),
    .req_ready(req_ready[1]), .winc(winc[1]), .wdata(wdata[1]), .wfull(wfull),
    .awfull(awfull), .grant(grant[1]), .busy(busy[1]), .beat_count(beat_count[1])
  );

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t got %0h want %0h", nm, k, $time, act, exp);
    end
  endtask

  // Model: owner (-1 = none), last owner, beats in current burst, total beats,
  // and the next expected sequence number per requester.
  int m_own   [2];
  int m_last  [2];
  int m_burst [2];
  int m_cnt   [2];
  int m_exp   [2][NREQ];

  // Observations for the hand-computed expectations.
  int gq0[$], gq1[$], bq0[$], bq1[$];
  int cur_beats [2];
  logic [NREQ-1:0] prev_g [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1; m_last[k] = NREQ - 1; m_burst[k] = 0; m_cnt[k] = 0;
      cur_beats[k] = 0; prev_g[k] = '0; hs[k] = '0;
      for (int i = 0; i < NREQ; i++) begin
        m_exp[k][i] = 0;
        seq[k][i]   = 0;
      end
    end
  end

  int o, p, gi;
  logic [NREQ-1:0] eg, er;
  logic ew, bt, fnd, thr;

  always @(negedge wclk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        o  = m_own[k];
        eg = '0;
        er = '0;
        ew = 1'b0;
        if (o >= 0) begin
          eg[o] = 1'b1;
          if (!wfull) er[o] = 1'b1;
          ew = req_valid[o] && !wfull;
        end
        check("grant", k, 32'(grant[k]), 32'(eg));
        check("busy", k, 32'(busy[k]), 32'(o >= 0));
        check("req_ready", k, 32'(req_ready[k]), 32'(er));
        check("winc", k, 32'(winc[k]), 32'(ew));
        check("beat_count", k, 32'(beat_count[k]), 32'(m_cnt[k] % 65536));
        if (ew) check("wdata", k, 32'(wdata[k]), 32'(o * 64 + (m_exp[k][o] % 64)));

        hs[k] = req_valid & req_ready[k];

        if (grant[k] != '0 && prev_g[k] == '0) begin
          gi = -1;
          for (int i = 0; i < NREQ; i++) if (grant[k][i]) gi = i;
          if (k == 0) gq0.push_back(gi); else gq1.push_back(gi);
        end
        if (winc[k]) cur_beats[k]++;
        if (grant[k] == '0 && prev_g[k] != '0) begin
          if (k == 0) bq0.push_back(cur_beats[k]); else bq1.push_back(cur_beats[k]);
          cur_beats[k] = 0;
        end
        prev_g[k] = grant[k];

        bt  = 1'b0;
        thr = (k == 0);
        if (o >= 0 && req_valid[o] && !wfull) begin
          bt = 1'b1;
          m_exp[k][o]++;
        end
        if (wrst) begin
          m_own[k] = -1; m_last[k] = NREQ - 1; m_burst[k] = 0; m_cnt[k] = 0;
        end else if (o < 0) begin
          fnd = 1'b0;
          for (int s = 1; s <= NREQ; s++) begin
            p = (m_last[k] + s) % NREQ;
            if (!fnd && req_valid[p]) begin
              fnd = 1'b1;
              m_own[k] = p;
            end
          end
          m_burst[k] = 0;
        end else begin
          if (bt) begin
            m_burst[k]++;
            m_cnt[k]++;
          end
          if ((bt && m_burst[k] == BURST_MAX) || !req_valid[o] ||
              (thr && awfull && (bt || wfull))) begin
            m_own[k]  = -1;
            m_last[k] = o;
          end
        end
      end
    end
  end

  always @(posedge wclk) begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++)
        if (hs[k][i]) seq[k][i]++;
  end

  task automatic cyc(input logic [NREQ-1:0] v, input logic f, input logic af,
                     input logic r);
    req_valid = v;
    wfull     = f;
    awfull    = af;
    wrst      = r;
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    cyc('0, 1'b0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0, 1'b1);
    gq0.delete(); gq1.delete(); bq0.delete(); bq1.delete();
    cur_beats[0] = 0;
    cur_beats[1] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = '0; wfull = 1'b0; awfull = 1'b0; wrst = 1'b1;
    @(posedge wclk);
    #1;
    chk_en = 1'b1;

    // Single requester streaming: 4 beats, 1 bubble, repeat.
    do_reset();
    repeat (20) cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    check("t1_beats20", 0, 32'(beat_count[0]), 32'd16);
    check("t1_beats20", 1, 32'(beat_count[1]), 32'd16);

    // All valid: rotation 0,1,2,3,0 with full bursts.
    do_reset();
    repeat (25) cyc(4'b1111, 1'b0, 1'b0, 1'b0);
    check("t2_ngrants", 0, 32'(gq0.size() >= 5), 32'd1);
    check("t2_g0", 0, 32'(gq0[0]), 32'd0);
    check("t2_g1", 0, 32'(gq0[1]), 32'd1);
    check("t2_g2", 0, 32'(gq0[2]), 32'd2);
    check("t2_g3", 0, 32'(gq0[3]), 32'd3);
    check("t2_g4", 0, 32'(gq0[4]), 32'd0);
    for (int j = 0; j < 4; j++) check("t2_burst", 0, 32'(bq0[j]), 32'd4);

    // Requester 2 with a 3-cycle full stall after beat 2.
    do_reset();
    repeat (3) cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(4'b0100, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    check("t3_owner", 0, 32'(gq0[0]), 32'd2);
    check("t3_burst", 0, 32'(bq0[0]), 32'd4);
    check("t3_total", 0, 32'(beat_count[0]), 32'd4);

    // Almost-full during beat 2: throttled instance stops at 2, other runs 4.
    do_reset();
    repeat (2) cyc(4'b0011, 1'b0, 1'b0, 1'b0);
    cyc(4'b0011, 1'b0, 1'b1, 1'b0);
    repeat (6) cyc(4'b0011, 1'b0, 1'b0, 1'b0);
    check("t4_thr_burst", 0, 32'(bq0[0]), 32'd2);
    check("t4_thr_next", 0, 32'(gq0[1]), 32'd1);
    check("t4_nothr_burst", 1, 32'(bq1[0]), 32'd4);
    check("t4_nothr_next", 1, 32'(gq1[1]), 32'd1);

    // Requester 1 drops valid after 2 beats; next grant goes to 3.
    do_reset();
    repeat (3) cyc(4'b1010, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(4'b1000, 1'b0, 1'b0, 1'b0);
    check("t5_first", 0, 32'(gq0[0]), 32'd1);
    check("t5_burst", 0, 32'(bq0[0]), 32'd2);
    check("t5_next", 0, 32'(gq0[1]), 32'd3);

    // Reset during beat 3 of requester 0's burst.
    do_reset();
    repeat (3) cyc(4'b1111, 1'b0, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0, 1'b1);
    check("t6_grant", 0, 32'(grant[0]), 32'd0);
    check("t6_count", 0, 32'(beat_count[0]), 32'd0);
    repeat (2) cyc(4'b1111, 1'b0, 1'b0, 1'b0);
    check("t6_pre_beats", 0, 32'(bq0[0]), 32'd3);
    check("t6_ngrants", 0, 32'(gq0.size()), 32'd2);
    check("t6_after", 0, 32'(gq0[1]), 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
